// File: rtl/chg_pkg.sv
// Shared definitions for the change-list fetch stage and the Y filter that consumes it.
package chg_pkg;

    localparam int CHG_ENTRY_W = 80;

    localparam int ROW_HI  = 79;
    localparam int ROW_LO  = 64;
    localparam int COL_HI  = 63;
    localparam int COL_LO  = 48;
    localparam int REAL_HI = 47;
    localparam int REAL_LO = 24;
    localparam int IMG_HI  = 23;
    localparam int IMG_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRST_RD = 2'd1,
        ST_PRESENT  = 2'd2,
        ST_DONE     = 2'd3
    } chg_state_e;

endpackage

// File: rtl/chg_entry_reg.sv
// Entry holding register; loads either the SRAM read data or the prefetched entry.
module chg_entry_reg #(
    parameter int W = 80
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_sel_pf,
    input  logic [W-1:0] i_mem,
    input  logic [W-1:0] i_pf,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_q <= '0;
        else if (i_load)
            r_q <= i_sel_pf ? i_pf : i_mem;
    end

    assign o_q = r_q;

endmodule

// File: rtl/chg_fetch.sv
// Change-list fetch: streams packed entries from SRAM to the Y filter, one per entry_done,
// with a single prefetch slot so consecutive entries need no bubble.
module chg_fetch
    import chg_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int ENTRY_W = CHG_ENTRY_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    num_entries,
    output logic [ADDR_W-1:0]  chgMem_addr,
    output logic               chgMem_rd_en,
    input  logic [ENTRY_W-1:0] chgMem_data,
    output logic [15:0]        fetch_row,
    output logic [15:0]        fetch_col,
    output logic [23:0]        fetch_real,
    output logic [23:0]        fetch_img,
    output logic               fetch_valid,
    input  logic               entry_done,
    output logic               busy,
    output logic               all_done
);

    chg_state_e        r_state, w_next;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_first;
    logic              r_pf_valid;
    logic              r_fetch_valid;
    logic              r_all_done;

    logic              w_more;
    logic              w_rd_en;
    logic              w_out_ld;
    logic              w_out_sel_pf;
    logic              w_pf_ld;
    logic [ENTRY_W-1:0] w_out_q;
    logic [ENTRY_W-1:0] w_pf_q;

    // r_rd_ptr is the index of the next entry still to be read from SRAM.
    assign w_more = (r_rd_ptr < r_count);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_rd_en      = 1'b0;
        w_out_ld     = 1'b0;
        w_out_sel_pf = 1'b0;
        w_pf_ld      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_next = (num_entries == '0) ? ST_DONE : ST_FIRST_RD;
            end
            ST_FIRST_RD: begin
                w_rd_en  = 1'b1;
                w_out_ld = 1'b1;
                w_next   = ST_PRESENT;
            end
            ST_PRESENT: begin
                w_rd_en = r_first && w_more;
                if (entry_done) begin
                    if (r_pf_valid) begin
                        w_out_ld     = 1'b1;
                        w_out_sel_pf = 1'b1;
                    end else if (w_rd_en) begin
                        // Data for k+1 lands on this edge: bypass the prefetch slot.
                        w_out_ld = 1'b1;
                    end else if (!w_more) begin
                        w_next = ST_DONE;
                    end
                end else begin
                    w_pf_ld = w_rd_en;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_first       <= 1'b0;
            r_pf_valid    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_all_done    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_count    <= num_entries;
                r_rd_ptr   <= '0;
                r_all_done <= 1'b0;
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (r_state == ST_DONE)
                r_all_done <= 1'b1;
            r_first <= w_out_ld;
            if (w_out_ld)
                r_fetch_valid <= 1'b1;
            else if (r_state == ST_PRESENT && w_next == ST_DONE)
                r_fetch_valid <= 1'b0;
            if (w_pf_ld)
                r_pf_valid <= 1'b1;
            else if (w_out_sel_pf)
                r_pf_valid <= 1'b0;
        end
    end

    chg_entry_reg #(.W(ENTRY_W)) u_out_reg (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_out_ld),
        .i_sel_pf (w_out_sel_pf),
        .i_mem    (chgMem_data),
        .i_pf     (w_pf_q),
        .o_q      (w_out_q)
    );

    chg_entry_reg #(.W(ENTRY_W)) u_pf_reg (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_pf_ld),
        .i_sel_pf (1'b0),
        .i_mem    (chgMem_data),
        .i_pf     (w_out_q),
        .o_q      (w_pf_q)
    );

    assign chgMem_rd_en = w_rd_en;
    assign chgMem_addr  = r_rd_ptr[ADDR_W-1:0];
    assign fetch_row    = w_out_q[ROW_HI:ROW_LO];
    assign fetch_col    = w_out_q[COL_HI:COL_LO];
    assign fetch_real   = w_out_q[REAL_HI:REAL_LO];
    assign fetch_img    = w_out_q[IMG_HI:IMG_LO];
    assign fetch_valid  = r_fetch_valid;
    assign busy         = (r_state == ST_FIRST_RD) || (r_state == ST_PRESENT);
    assign all_done     = r_all_done;

endmodule

// File: tb/tb_chg_fetch.sv
// Directed bench for chg_fetch with a same-cycle-return SRAM model and a read log.
module tb_chg_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [10:0] num_entries = '0;
    logic [9:0]  chgMem_addr;
    logic        chgMem_rd_en;
    logic [79:0] chgMem_data;
    logic [15:0] fetch_row, fetch_col;
    logic [23:0] fetch_real, fetch_img;
    logic        fetch_valid;
    logic        entry_done = 1'b0;
    logic        busy, all_done;

    logic [79:0] mem [0:1023];
    logic [9:0]  rd_log [$];

    int n_chk = 0;
    int n_err = 0;

    chg_fetch #(.ADDR_W(10), .ENTRY_W(80)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_entries  (num_entries),
        .chgMem_addr  (chgMem_addr),
        .chgMem_rd_en (chgMem_rd_en),
        .chgMem_data  (chgMem_data),
        .fetch_row    (fetch_row),
        .fetch_col    (fetch_col),
        .fetch_real   (fetch_real),
        .fetch_img    (fetch_img),
        .fetch_valid  (fetch_valid),
        .entry_done   (entry_done),
        .busy         (busy),
        .all_done     (all_done)
    );

    always #5 clock = ~clock;

    // Read data is on the bus by the edge that ends the read-strobe cycle.
    assign chgMem_data = chgMem_rd_en ? mem[chgMem_addr] : '0;

    always @(posedge clock)
        if (reset && chgMem_rd_en)
            rd_log.push_back(chgMem_addr);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic        done;
        logic        fv;
        logic [15:0] row;
        logic        rd_en;
        logic        busy;
        logic        all_done;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [79:0] pack(input logic [15:0] r, input logic [15:0] c,
                                         input logic [23:0] re, input logic [23:0] im);
        return {r, c, re, im};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_rows(input int base);
        for (int i = 0; i < 4; i++)
            mem[i] = pack(16'(base + i), 16'(16'h0100 + i), 24'(24'h001000 + i), 24'(24'hFFF000 + i));
    endtask

    initial begin
        int idx, gaps, bad, mx;
        logic [15:0] lc;
        logic [23:0] lr, li;

        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        chk("rst fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst rd_en",       32'(chgMem_rd_en), 32'd0);
        chk("rst addr",        32'(chgMem_addr), 32'd0);
        chk("rst busy",        32'(busy), 32'd0);
        chk("rst all_done",    32'(all_done), 32'd0);
        chk("rst row",         32'(fetch_row), 32'd0);
        reset = 1'b1;
        tick();

        // ---------------- t1: 3 entries, entry_done 4 cycles after valid ----------------
        load_rows(5);
        rd_log.delete();
        start = 1'b1; num_entries = 11'd3;
        tick();
        start = 1'b0;
        chk("t1 rd_en E", 32'(chgMem_rd_en), 32'd1);
        chk("t1 addr E",  32'(chgMem_addr), 32'd0);
        tick();
        chk("t1 busy", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1 e%0d valid", k), 32'(fetch_valid), 32'd1);
            chk($sformatf("t1 e%0d row", k), 32'(fetch_row), 32'(5 + k));
            repeat (3) tick();
            chk($sformatf("t1 e%0d hold", k), 32'(fetch_row), 32'(5 + k));
            entry_done = 1'b1;
            tick();
            entry_done = 1'b0;
        end
        chk("t1 valid drop",  32'(fetch_valid), 32'd0);
        chk("t1 all_done D",  32'(all_done), 32'd0);
        tick();
        chk("t1 all_done D+1", 32'(all_done), 32'd1);
        chk("t1 busy end",     32'(busy), 32'd0);
        chk("t1 reads", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < rd_log.size() && i < 3; i++)
            chk($sformatf("t1 read%0d addr", i), 32'(rd_log[i]), 32'(i));

        // ---------------- t2: 4 entries, entry_done held high (table) ----------------
        load_rows(0);
        rd_log.delete();
        //            start done fv  row    rd  busy ad
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
        num_entries = 11'd4;
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].start;
            entry_done = tbl[i].done;
            tick();
            chk($sformatf("t2[%0d] fv", i),       32'(fetch_valid), 32'(tbl[i].fv));
            chk($sformatf("t2[%0d] rd_en", i),    32'(chgMem_rd_en), 32'(tbl[i].rd_en));
            chk($sformatf("t2[%0d] busy", i),     32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t2[%0d] all_done", i), 32'(all_done), 32'(tbl[i].all_done));
            if (tbl[i].fv)
                chk($sformatf("t2[%0d] row", i), 32'(fetch_row), 32'(tbl[i].row));
        end
        start = 1'b0; entry_done = 1'b0;
        chk("t2 reads", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < rd_log.size() && i < 4; i++)
            chk($sformatf("t2 read%0d addr", i), 32'(rd_log[i]), 32'(i));

        // ---------------- t3: zero entries ----------------
        rd_log.delete();
        start = 1'b1; num_entries = 11'd0;
        tick();
        start = 1'b0;
        chk("t3 all_done cleared E", 32'(all_done), 32'd0);
        chk("t3 rd_en E", 32'(chgMem_rd_en), 32'd0);
        tick();
        chk("t3 all_done E+1", 32'(all_done), 32'd1);
        repeat (2) tick();
        chk("t3 all_done sticky", 32'(all_done), 32'd1);
        chk("t3 no reads", 32'(rd_log.size()), 32'd0);

        // ---------------- t4: start while busy, entry_done while not valid ----------------
        load_rows(5);
        rd_log.delete();
        start = 1'b1; num_entries = 11'd2; entry_done = 1'b1;
        tick();
        chk("t4 busy E", 32'(busy), 32'd1);
        chk("t4 fv E",   32'(fetch_valid), 32'd0);
        num_entries = 11'd3;
        tick();
        chk("t4 fv E+1",  32'(fetch_valid), 32'd1);
        chk("t4 row E+1", 32'(fetch_row), 32'd5);
        num_entries = 11'd0; entry_done = 1'b0;
        tick();
        chk("t4 row hold", 32'(fetch_row), 32'd5);
        chk("t4 busy",     32'(busy), 32'd1);
        start = 1'b0; entry_done = 1'b1;
        tick();
        chk("t4 row second", 32'(fetch_row), 32'd6);
        chk("t4 fv second",  32'(fetch_valid), 32'd1);
        tick();
        entry_done = 1'b0;
        chk("t4 fv drop", 32'(fetch_valid), 32'd0);
        tick();
        chk("t4 all_done", 32'(all_done), 32'd1);
        chk("t4 reads", 32'(rd_log.size()), 32'd2);

        // ---------------- t5: reset during an outstanding read ----------------
        rd_log.delete();
        start = 1'b1; num_entries = 11'd3;
        tick();
        start = 1'b0;
        chk("t5 rd_en before rst", 32'(chgMem_rd_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5 rst rd_en",    32'(chgMem_rd_en), 32'd0);
        chk("t5 rst fv",       32'(fetch_valid), 32'd0);
        chk("t5 rst busy",     32'(busy), 32'd0);
        chk("t5 rst all_done", 32'(all_done), 32'd0);
        chk("t5 rst addr",     32'(chgMem_addr), 32'd0);
        chk("t5 rst row",      32'(fetch_row), 32'd0);
        #2 reset = 1'b1;
        repeat (2) tick();
        chk("t5 idle fv",    32'(fetch_valid), 32'd0);
        chk("t5 idle busy",  32'(busy), 32'd0);
        chk("t5 aborted reads", 32'(rd_log.size()), 32'd0);
        start = 1'b1; num_entries = 11'd2;
        tick();
        start = 1'b0;
        chk("t5 rerun addr", 32'(chgMem_addr), 32'd0);
        tick();
        chk("t5 rerun row", 32'(fetch_row), 32'd5);
        entry_done = 1'b1;
        for (int c = 0; c < 20 && all_done !== 1'b1; c++) tick();
        entry_done = 1'b0;
        chk("t5 rerun all_done", 32'(all_done), 32'd1);
        chk("t5 rerun reads", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() > 0)
            chk("t5 rerun first addr", 32'(rd_log[0]), 32'd0);

        // ---------------- t6: full 1024 entries, extreme values at the top address ----------------
        for (int i = 0; i < 1024; i++)
            mem[i] = pack(16'(i), 16'(i ^ 16'h5A5A), 24'(i * 3), 24'(~i));
        mem[1023] = pack(16'd1023, 16'hABCD, 24'h800000, 24'hFFFFFF);
        rd_log.delete();
        start = 1'b1; num_entries = 11'd1024; entry_done = 1'b1;
        tick();
        start = 1'b0;
        idx = 0; gaps = 0; bad = 0;
        lc = '0; lr = '0; li = '0;
        for (int c = 0; c < 1100 && all_done !== 1'b1; c++) begin
            if (fetch_valid) begin
                if (fetch_row !== 16'(idx)) bad++;
                if (idx == 1023) begin
                    lc = fetch_col; lr = fetch_real; li = fetch_img;
                end
                idx++;
            end else if (idx > 0 && idx < 1024) begin
                gaps++;
            end
            tick();
        end
        entry_done = 1'b0;
        chk("t6 all_done", 32'(all_done), 32'd1);
        chk("t6 entries",  32'(idx), 32'd1024);
        chk("t6 order",    32'(bad), 32'd0);
        chk("t6 bubbles",  32'(gaps), 32'd0);
        chk("t6 last col",  32'(lc), 32'h0000ABCD);
        chk("t6 last real", 32'(lr), 32'h00800000);
        chk("t6 last img",  32'(li), 32'h00FFFFFF);
        chk("t6 reads", 32'(rd_log.size()), 32'd1024);
        mx = 0;
        for (int i = 0; i < rd_log.size(); i++)
            if (int'(rd_log[i]) > mx) mx = int'(rd_log[i]);
        chk("t6 max addr", 32'(mx), 32'd1023);
        if (rd_log.size() == 1024) begin
            chk("t6 first addr", 32'(rd_log[0]), 32'd0);
            chk("t6 last addr",  32'(rd_log[1023]), 32'd1023);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
